// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus responder.
// State encoding, data width, wait-counter width and parity helper.
package mem_bus_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  function automatic logic even_par(
    input logic [DATA_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port synchronous RAM with write enable.
// Read data is registered and held until the next read.
module mem_bus_ram #(
  parameter int AW    = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array: contents survive reset.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read register: only updated by a read access.
  always_ff @(posedge clk) begin
    if (reset)          rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the DLX strobe/acknowledge bus.
// Optional word parity and perr output with MEM_PARITY_EN.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AS_N,
  input  logic              WR_N,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              ACK_N,
  output logic [1:0]        STATE
`ifdef MEM_PARITY_EN
  ,output logic             perr
`endif
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_e              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_n_q;
  logic [DATA_W-1:0]   di_q;

  logic                accept;
  logic                ram_en;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wd;
  logic [MEM_W-1:0]    ram_wdata;
  logic [MEM_W-1:0]    ram_rdata;
  logic                unused_addr;

  assign unused_addr = ^ADDR[31:ADDR_W];

  assign accept = (state == ST_IDLE) && !AS_N;

  // With zero wait states the access happens on the accepting edge,
  // so the live bus values bypass the request latches.
  assign ram_addr = accept ? ADDR[ADDR_W-1:0] : addr_q;
  assign ram_we   = accept ? !WR_N : !wr_n_q;
  assign ram_wd   = accept ? DI : di_q;
  assign ram_en   = !reset && (state_nx == ST_ACK);

`ifdef MEM_PARITY_EN
  assign ram_wdata = {even_par(ram_wd), ram_wd};
  assign perr = (state == ST_ACK) && wr_n_q &&
                (even_par(ram_rdata[DATA_W-1:0]) != ram_rdata[DATA_W]);
`else
  assign ram_wdata = ram_wd;
`endif

  assign DO    = ram_rdata[DATA_W-1:0];
  assign STATE = state;

  // Next-state and wait counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (!AS_N) begin
          cnt_nx   = WAIT_LD;
          state_nx = (WAIT_LD != '0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (AS_N) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nx = ST_ACK;
        end
      end
      ST_ACK: state_nx = ST_RELEASE;
      ST_RELEASE: begin
        if (AS_N) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, counter and registered acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ACK_N <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ACK_N <= (state_nx != ST_ACK);
    end
  end

  // Request latches, captured on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      wr_n_q <= 1'b1;
      di_q   <= '0;
    end else if (accept) begin
      addr_q <= ADDR[ADDR_W-1:0];
      wr_n_q <= WR_N;
      di_q   <= DI;
    end
  end

  mem_bus_ram #(
    .AW    (ADDR_W),
    .WIDTH (MEM_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder.
// Vector table, directed corner cases and randomized transactions.
module tb_mem_bus_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        as_n, wr_n;
  logic [31:0] addr, di, do_v;
  logic        ack_n;
  logic [1:0]  st;

  logic        as0_n, wr0_n;
  logic [31:0] addr0, di0, do0;
  logic        ack0_n;
  logic [1:0]  st0;

`ifdef MEM_PARITY_EN
  logic        perr, perr0;
  logic [255:0] corrupt;
`endif

  always #5 clk = ~clk;

  mem_bus_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .reset (reset),
    .AS_N  (as_n),
    .WR_N  (wr_n),
    .ADDR  (addr),
    .DI    (di),
    .DO    (do_v),
    .ACK_N (ack_n),
    .STATE (st)
`ifdef MEM_PARITY_EN
    ,.perr (perr)
`endif
  );

  mem_bus_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .AS_N  (as0_n),
    .WR_N  (wr0_n),
    .ADDR  (addr0),
    .DI    (di0),
    .DO    (do0),
    .ACK_N (ack0_n),
    .STATE (st0)
`ifdef MEM_PARITY_EN
    ,.perr (perr0)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [256];
  logic [31:0] last_do;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    int          h;
    int          exp_acks;
    logic [31:0] exp_do;
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One bus transaction: strobe low for h edges, then high for g edges.
  // The access completes only if the strobe is seen low W+1 times.
  task automatic run_txn(input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int h, input int g,
                         output int acks, output logic [31:0] ack_do);
    bit access;
    int exp_st;
    access = (h >= W + 1);
    acks   = 0;
    ack_do = '0;
    for (int k = 0; k < h + g; k++) begin
      as_n = (k < h) ? 1'b0 : 1'b1;
      if (k == 0) begin
        wr_n = !wr;
        addr = a;
        di   = d;
      end else begin
        wr_n = 1'($urandom);
        addr = $urandom;
        di   = $urandom;
      end
      cyc();
      if (access && k == W) begin
        if (wr) begin
          mem_m[a[7:0]] = d;
`ifdef MEM_PARITY_EN
          corrupt[a[7:0]] = 1'b0;
`endif
        end else begin
          last_do = mem_m[a[7:0]];
        end
      end
      chk("ack_n", {31'b0, ack_n}, {31'b0, !(access && k == W)});
      chk("do", do_v, last_do);
      if (k < h) begin
        exp_st = (k < W) ? 1 : ((k == W) ? 2 : 3);
        chk("state", {30'b0, st}, exp_st);
      end
`ifdef MEM_PARITY_EN
      chk("perr", {31'b0, perr},
          {31'b0, access && !wr && k == W && corrupt[a[7:0]]});
`endif
      if (!ack_n) begin
        acks++;
        ack_do = do_v;
      end
    end
    chk("end_idle", {30'b0, st}, 0);
  endtask

  initial begin
    int          n;
    logic [31:0] v;

    reset = 1'b1;
    as_n  = 1'b1; wr_n = 1'b1; addr = '0; di = '0;
    as0_n = 1'b1; wr0_n = 1'b1; addr0 = '0; di0 = '0;
    last_do = '0;
`ifdef MEM_PARITY_EN
    corrupt = '0;
`endif
    repeat (3) cyc();
    chk("rst_ack", {31'b0, ack_n}, 1);
    chk("rst_do", do_v, 0);
    chk("rst_state", {30'b0, st}, 0);
    chk("rst_ack0", {31'b0, ack0_n}, 1);
    chk("rst_state0", {30'b0, st0}, 0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 256; i++) begin
      run_txn(1'b1, i, 32'hA500_0000 | i, W + 1, 2, n, v);
    end

    tv[0] = '{1'b1, 32'd5,     32'hDEADBEEF, 3,  1, 32'h0};
    tv[1] = '{1'b0, 32'd5,     32'h0,        3,  1, 32'hDEADBEEF};
    tv[2] = '{1'b1, 32'd3,     32'h12345678, 2,  0, 32'h0};
    tv[3] = '{1'b0, 32'd3,     32'h0,        3,  1, 32'hA500_0003};
    tv[4] = '{1'b1, 32'h105,   32'hCAFEF00D, 3,  1, 32'hA500_0003};
    tv[5] = '{1'b0, 32'h005,   32'h0,        3,  1, 32'hCAFEF00D};
    tv[6] = '{1'b0, 32'h20,    32'h0,        10, 1, 32'hA500_0020};

    for (int i = 0; i < 7; i++) begin
      run_txn(tv[i].wr, tv[i].a, tv[i].d, tv[i].h, 3, n, v);
      chk($sformatf("vec%0d_acks", i), n, tv[i].exp_acks);
      if (tv[i].exp_acks > 0)
        chk($sformatf("vec%0d_do", i), v, tv[i].exp_do);
    end

    as_n = 1'b0; wr_n = 1'b1; addr = 32'd9;
    for (int k = 0; k <= W; k++) cyc();
    chk("pre_rst_ack", {31'b0, ack_n}, 0);
    chk("pre_rst_do", do_v, 32'hA500_0009);
    reset = 1'b1;
    cyc();
    chk("rst_mid_ack", {31'b0, ack_n}, 1);
    chk("rst_mid_state", {30'b0, st}, 0);
    reset = 1'b0;
    as_n  = 1'b1;
    last_do = '0;
    cyc();
    chk("rst_mid_do", do_v, 0);
    run_txn(1'b0, 32'd9, 32'h0, W + 1, 2, n, v);
    chk("ram_kept", v, 32'hA500_0009);

    as0_n = 1'b0; wr0_n = 1'b0; addr0 = 32'd7; di0 = 32'h0BAD_F00D;
    cyc();
    chk("z_wr_ack", {31'b0, ack0_n}, 0);
    chk("z_wr_st2", {30'b0, st0}, 2);
    as0_n = 1'b1; wr0_n = 1'b1;
    cyc();
    chk("z_wr_st3", {30'b0, st0}, 3);
    chk("z_wr_ack_hi", {31'b0, ack0_n}, 1);
    cyc();
    chk("z_wr_st0", {30'b0, st0}, 0);
    as0_n = 1'b0; wr0_n = 1'b1; addr0 = 32'd7;
    cyc();
    chk("z_rd_ack", {31'b0, ack0_n}, 0);
    chk("z_rd_st2", {30'b0, st0}, 2);
    chk("z_rd_do", do0, 32'h0BAD_F00D);
    as0_n = 1'b1;
    cyc();
    chk("z_rd_st3", {30'b0, st0}, 3);
    cyc();
    chk("z_rd_st0", {30'b0, st0}, 0);
    chk("z_do_hold", do0, 32'h0BAD_F00D);

`ifdef MEM_PARITY_EN
    dut.u_ram.mem[64] = dut.u_ram.mem[64] ^ 33'h1;
    mem_m[64] = mem_m[64] ^ 32'h1;
    corrupt[64] = 1'b1;
    run_txn(1'b0, 32'd64, 32'h0, W + 1, 2, n, v);
    run_txn(1'b0, 32'd65, 32'h0, W + 1, 2, n, v);
`endif

    for (int i = 0; i < 300; i++) begin
      run_txn(1'($urandom), $urandom, $urandom,
              $urandom_range(1, W + 4), $urandom_range(2, 4), n, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
